// File: rtl/seg_pkg.sv
// seg_pkg: shared hex-to-segment table (active-high a..g) and clog2 helper
package seg_pkg;
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: nibble in -> active-high {g,f,e,d,c,b,a} pattern out
module seg_hex_decode import seg_pkg::*; (
  input  logic [3:0] nib,
  output logic [6:0] pat
);
  assign pat = HEX_SEG[nib];
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 7-seg scan driver (clk, rst, value, dp_mask, lz_blank, bright, load -> seg, sel, frame_done)
module seg_scan_driver import seg_pkg::*; #(
  parameter int DIGITS      = 6,
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD        = 4,
  parameter int BRIGHT_W    = 4,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit SEL_ACT_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  lz_blank,
  input  logic [BRIGHT_W-1:0]   bright,
  input  logic                  load,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     sel,
  output logic                  frame_done
);
  localparam int IW = clog2(DIGITS) < 1 ? 1 : clog2(DIGITS);
  localparam int CW = clog2(SCAN_DIV) < 1 ? 1 : clog2(SCAN_DIV);
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [BRIGHT_W-1:0] pwm;
  logic [4*DIGITS-1:0] pend_val, act_val, src_val;
  logic [DIGITS-1:0] pend_dp, act_dp, src_dp;
  logic pending, slot_end, frame_start, frame_end, on, hi_zero, blank;
  logic [3:0] nib;
  logic [6:0] pat;
  assign slot_end = cnt == CW'(SCAN_DIV - 1);
  assign frame_start = cnt == '0 && idx == '0;
  assign frame_end = slot_end && idx == IW'(DIGITS - 1);
  // the transfer cycle already displays the incoming buffer so no slot mixes frames
  assign src_val = frame_start && pending ? pend_val : act_val;
  assign src_dp = frame_start && pending ? pend_dp : act_dp;
  assign nib = 4'(src_val >> {idx, 2'b00});
  assign on = cnt >= CW'(DEAD) && (pwm < bright || &bright);
  always_comb begin
    hi_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++)
      if (j >= int'(idx) && src_val[4*j +: 4] != 4'd0) hi_zero = 1'b0;
  end
  assign blank = lz_blank && idx != '0 && hi_zero;
  seg_hex_decode u_dec (.nib(nib), .pat(pat));
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      pwm <= '0;
      pending <= 1'b0;
      pend_val <= '0;
      pend_dp <= '0;
      act_val <= '0;
      act_dp <= '0;
      seg <= {8{SEG_ACT_LOW}};
      sel <= {DIGITS{SEL_ACT_LOW}};
      frame_done <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
      pwm <= pwm + 1'b1;
      frame_done <= frame_end;
      if (frame_start && pending) begin
        act_val <= pend_val;
        act_dp <= pend_dp;
      end
      if (load) begin
        pend_val <= value;
        pend_dp <= dp_mask;
      end
      pending <= load || (pending && !frame_start);
      seg <= (on ? {src_dp[idx], blank ? 7'd0 : pat} : 8'd0) ^ {8{SEG_ACT_LOW}};
      sel <= (on ? DIGITS'(1) << idx : '0) ^ {DIGITS{SEL_ACT_LOW}};
    end
  end
endmodule
